uart_reply_tx: RTL and testbench

- Transmit-side companion to the UART command parser.
- Accepts one reply request per transaction and formats it into an ASCII byte frame:
  - acknowledge,
  - failure, or
  - a command character plus a 3-digit decimal value.
- Streams the frame byte-by-byte to the UART transmitter over a valid/ready handshake.
- Sits between the control logic and the UART TX serializer. It reports accepted settings (`$`/`#` values) and errors back to the host.

---
 rtl/uart_reply_tx_if.sv | 26 ++
 rtl/uart_reply_tx.sv | 158 +++++++++++++++
 tb/tb_uart_reply_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_reply_tx_if.sv
// uart_reply_tx_if: the reply request handshake and the byte stream to the UART TX serializer.
//   req_valid/req_ready      request handshake (master drives valid, slave drives ready)
//   req_type/cmd/value       request payload: 0 ACK, 1 FAIL, 2 VALUE, 3 FAIL
//   to_uart_valid/data/ready byte stream towards the UART TX (slave drives valid/data)
//   frame_done               pulse when the last byte of a frame is accepted
interface uart_reply_tx_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_type;
    logic [7:0] req_cmd;
    logic [7:0] req_value;
    logic       to_uart_valid;
    logic [7:0] to_uart_data;
    logic       to_uart_ready;
    logic       frame_done;

    modport master (
        output req_valid, req_type, req_cmd, req_value, to_uart_ready,
        input  req_ready, to_uart_valid, to_uart_data, frame_done
    );

    modport slave (
        input  req_valid, req_type, req_cmd, req_value, to_uart_ready,
        output req_ready, to_uart_valid, to_uart_data, frame_done
    );
endinterface

// File: rtl/uart_reply_tx.sv
// uart_reply_tx: formats one reply request into an ASCII frame and streams it to the UART TX.
//   Frames: ACK "OK", FAIL "ER", VALUE <cmd><hundreds><tens><ones>, each ended by [CR] LF.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_reply_tx_if.slave: request handshake in, byte stream out, frame_done pulse
module uart_reply_tx #(
    parameter bit         SEND_CR = 1'b1,
    parameter logic [7:0] ACK_C0  = 8'h4F,
    parameter logic [7:0] ACK_C1  = 8'h4B,
    parameter logic [7:0] ERR_C0  = 8'h45,
    parameter logic [7:0] ERR_C1  = 8'h52
) (
    input  logic            clk,
    input  logic            rst,
    uart_reply_tx_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StConvert, StSend} state_e;

    state_e     state_q, state_d;
    logic       is_value_q, is_value_d;
    logic       is_ack_q, is_ack_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [2:0] last_idx;
    logic       send_accept;

    // Byte at position idx of the frame described by the given fields.
    function automatic logic [7:0] frame_byte(input logic       is_value,
                                              input logic       is_ack,
                                              input logic [7:0] cmd,
                                              input logic [3:0] h,
                                              input logic [3:0] t,
                                              input logic [3:0] o,
                                              input logic [2:0] idx);
        logic [2:0] body;
        logic [7:0] b;
        body = is_value ? 3'd4 : 3'd2;
        b    = 8'h0A;
        if (idx == body) begin
            b = SEND_CR ? 8'h0D : 8'h0A;
        end else if (idx > body) begin
            b = 8'h0A;
        end else if (is_value) begin
            case (idx)
                3'd0:    b = cmd;
                3'd1:    b = 8'h30 + {4'h0, h};
                3'd2:    b = 8'h30 + {4'h0, t};
                default: b = 8'h30 + {4'h0, o};
            endcase
        end else if (is_ack) begin
            b = (idx == 3'd0) ? ACK_C0 : ACK_C1;
        end else begin
            b = (idx == 3'd0) ? ERR_C0 : ERR_C1;
        end
        return b;
    endfunction

    assign last_idx    = (is_value_q ? 3'd4 : 3'd2) + {2'b00, SEND_CR};
    assign send_accept = (state_q == StSend) && bus.to_uart_ready;

    assign bus.req_ready     = (state_q == StIdle);
    assign bus.to_uart_valid = (state_q == StSend);
    assign bus.to_uart_data  = data_q;
    assign bus.frame_done    = !rst && send_accept && (idx_q == last_idx);

    always_comb begin
        state_d    = state_q;
        is_value_d = is_value_q;
        is_ack_d   = is_ack_q;
        cmd_d      = cmd_q;
        rem_d      = rem_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        idx_d      = idx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    is_value_d = (bus.req_type == 2'd2);
                    is_ack_d   = (bus.req_type == 2'd0);
                    cmd_d      = bus.req_cmd;
                    idx_d      = 3'd0;
                    if (bus.req_type == 2'd2) begin
                        state_d = StConvert;
                        rem_d   = bus.req_value;
                        hund_d  = 4'd0;
                        tens_d  = 4'd0;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StConvert: begin
                if (rem_q >= 8'd100) begin
                    rem_d  = rem_q - 8'd100;
                    hund_d = hund_q + 4'd1;
                end else if (rem_q >= 8'd10) begin
                    rem_d  = rem_q - 8'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d  = rem_q[3:0];
                    idx_d   = 3'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (bus.to_uart_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = StIdle;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Register the byte for the next cycle so data is stable and there is no bubble.
        data_d = (state_d == StSend) ?
                 frame_byte(is_value_d, is_ack_d, cmd_d, hund_d, tens_d, ones_d, idx_d) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_value_q <= 1'b0;
            is_ack_q   <= 1'b0;
            cmd_q      <= 8'h00;
            rem_q      <= 8'h00;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            idx_q      <= 3'd0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            is_value_q <= is_value_d;
            is_ack_q   <= is_ack_d;
            cmd_q      <= cmd_d;
            rem_q      <= rem_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_reply_tx.sv
module tb_uart_reply_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_reply_tx_if bus();
    uart_reply_tx_if bus_lf();

    uart_reply_tx #(.SEND_CR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    uart_reply_tx #(.SEND_CR(1'b0)) dut_lf (
        .clk (clk),
        .rst (rst),
        .bus (bus_lf.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame from the reply rules: decimal digits via plain division.
    task automatic build(input int kind, input logic [7:0] cmd, input int v, input bit cr);
        exp_q.delete();
        if (kind == 2) begin
            exp_q.push_back(cmd);
            exp_q.push_back(8'(48 + v / 100));
            exp_q.push_back(8'(48 + (v / 10) % 10));
            exp_q.push_back(8'(48 + v % 10));
        end else if (kind == 0) begin
            exp_q.push_back(8'h4F);
            exp_q.push_back(8'h4B);
        end else begin
            exp_q.push_back(8'h45);
            exp_q.push_back(8'h52);
        end
        if (cr) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Called at a negedge during an idle cycle. Checks idle outputs, issues a request and
    // follows the frame to its last byte. abort_at >= 0 resets the DUT before that byte.
    task automatic run_frame(input int kind, input logic [7:0] cmd, input int v,
                             input int stall_idx, input int stall_len, input int busy_idx,
                             input bit rand_bp, input bit hold, input int abort_at);
        int conv;
        int exp_conv;
        int stalls;
        build(kind, cmd, v, 1'b1);
        exp_conv = (kind == 2) ? (v / 100 + (v % 100) / 10 + 1) : 0;
        #1;
        chk("idle_valid", 32'(bus.to_uart_valid), 32'd0);
        chk("idle_data", 32'(bus.to_uart_data), 32'h00);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_done", 32'(bus.frame_done), 32'd0);
        bus.req_valid     = 1'b1;
        bus.req_type      = 2'(kind);
        bus.req_cmd       = cmd;
        bus.req_value     = 8'(v);
        bus.to_uart_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = hold;
        conv = 0;
        for (int k = 0; k < 40; k++) begin
            bus.to_uart_ready = 1'($urandom);
            #1;
            if (bus.to_uart_valid) break;
            chk("conv_req_ready", 32'(bus.req_ready), 32'd0);
            chk("conv_done", 32'(bus.frame_done), 32'd0);
            conv++;
            @(negedge clk);
        end
        chk("convert_cycles", 32'(conv), 32'(exp_conv));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                bus.to_uart_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("abort_valid", 32'(bus.to_uart_valid), 32'd0);
                chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
                chk("abort_done", 32'(bus.frame_done), 32'd0);
                return;
            end
            if (i == busy_idx) begin
                bus.req_valid = 1'b1;
                bus.req_type  = 2'd2;
                bus.req_value = 8'(v) ^ 8'h5A;
            end
            if (i == busy_idx + 1) bus.req_valid = 1'b0;
            stalls = (i == stall_idx) ? stall_len : (rand_bp ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stalls; s++) begin
                bus.to_uart_ready = 1'b0;
                #1;
                chk("stall_valid", 32'(bus.to_uart_valid), 32'd1);
                chk("stall_data", 32'(bus.to_uart_data), 32'(exp_q[i]));
                chk("stall_done", 32'(bus.frame_done), 32'd0);
                @(negedge clk);
            end
            bus.to_uart_ready = 1'b1;
            #1;
            chk("byte_valid", 32'(bus.to_uart_valid), 32'd1);
            chk("byte_data", 32'(bus.to_uart_data), 32'(exp_q[i]));
            chk("byte_req_ready", 32'(bus.req_ready), 32'd0);
            chk("byte_done", 32'(bus.frame_done), 32'(i == exp_q.size() - 1));
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;  bus.req_type = 2'd0;  bus.req_cmd = 8'h00;
        bus.req_value = 8'h00; bus.to_uart_ready = 1'b0;
        bus_lf.req_valid = 1'b0;  bus_lf.req_type = 2'd0;  bus_lf.req_cmd = 8'h00;
        bus_lf.req_value = 8'h00; bus_lf.to_uart_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.to_uart_valid), 32'd0);
        chk("rst_data", 32'(bus.to_uart_data), 32'h00);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_lf_valid", 32'(bus_lf.to_uart_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // VALUE 154 with '#', no backpressure.
        run_frame(2, 8'h23, 154, -1, 0, -1, 1'b0, 1'b0, -1);
        // Digit corner values with '$'.
        run_frame(2, 8'h24, 0, -1, 0, -1, 1'b0, 1'b0, -1);
        run_frame(2, 8'h24, 9, -1, 0, -1, 1'b0, 1'b0, -1);
        run_frame(2, 8'h24, 100, -1, 0, -1, 1'b0, 1'b0, -1);
        run_frame(2, 8'h24, 255, -1, 0, -1, 1'b0, 1'b0, -1);
        run_frame(2, 8'h24, 99, -1, 0, -1, 1'b0, 1'b0, -1);
        // ACK with req_valid held, then FAIL accepted on the first idle cycle, then type 3.
        run_frame(0, 8'h00, 0, -1, 0, -1, 1'b0, 1'b1, -1);
        run_frame(1, 8'h00, 0, -1, 0, -1, 1'b0, 1'b0, -1);
        run_frame(3, 8'h00, 0, -1, 0, -1, 1'b0, 1'b0, -1);
        // Backpressure on byte index 2 for 5 cycles.
        run_frame(2, 8'h23, 42, 2, 5, -1, 1'b0, 1'b0, -1);
        // Request pulsed while busy must be ignored.
        run_frame(2, 8'h23, 77, -1, 0, 1, 1'b0, 1'b0, -1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("no_extra_frame", 32'(bus.to_uart_valid), 32'd0);
            @(negedge clk);
        end
        // Reset after three bytes, then a clean ACK.
        run_frame(2, 8'h23, 154, -1, 0, -1, 1'b0, 1'b0, 3);
        run_frame(0, 8'h00, 0, -1, 0, -1, 1'b0, 1'b0, -1);

        // Randomized requests with random backpressure.
        for (int n = 0; n < 25; n++) begin
            run_frame(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 255)),
                      -1, 0, -1, 1'b1, 1'b0, -1);
        end

        // LF-only variant: ACK frame is 4F 4B 0A.
        build(0, 8'h00, 0, 1'b0);
        bus_lf.req_valid = 1'b1;
        bus_lf.req_type  = 2'd0;
        bus_lf.to_uart_ready = 1'b1;
        @(negedge clk);
        bus_lf.req_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            chk("lf_valid", 32'(bus_lf.to_uart_valid), 32'd1);
            chk("lf_data", 32'(bus_lf.to_uart_data), 32'(exp_q[i]));
            chk("lf_done", 32'(bus_lf.frame_done), 32'(i == exp_q.size() - 1));
            @(negedge clk);
        end
        #1;
        chk("lf_idle_valid", 32'(bus_lf.to_uart_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
